// File: rtl/clint_ctrl.sv
// Core-local interrupt controller: sequences ecall / timer trap entry and
// mret return through the CSR write port, redirects fetch, and owns the
// mtime / mtimecmp timer pair.
module clint_ctrl #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] ECALL_CAUSE  = 64'd11,
  parameter logic [XLEN-1:0] TIMER_CAUSE  = 64'h8000_0000_0000_0007,
  parameter logic [63:0]     MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid_i,
  input  logic            id_ecall_i,
  input  logic            id_mret_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [XLEN-1:0] csr_mcause_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic            mtimecmp_wen_i,
  input  logic [63:0]     mtimecmp_wdata_i,
  output logic            clint_csr_wen_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic            hold_o,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic [63:0]     mtime_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_TRAP_SAVE = 2'b01,
    S_MRET_SAVE = 2'b10,
    S_JUMP      = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     mtime_q, mtimecmp_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            timer_pend_s;
  logic            wen_s, hold_s, jump_s;
  logic [XLEN-1:0] mepc_s, mcause_s, mstatus_s, jump_addr_s;

  // Timer interrupt is pending only while machine interrupts are globally enabled.
  assign timer_pend_s = (mtime_q >= mtimecmp_q) && csr_mstatus_i[3];

  // Next-state and sequencing outputs of the trap FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cause_d     = cause_q;
    target_d    = target_q;
    wen_s       = 1'b0;
    hold_s      = 1'b0;
    jump_s      = 1'b0;
    mepc_s      = {XLEN{1'b0}};
    mcause_s    = {XLEN{1'b0}};
    mstatus_s   = {XLEN{1'b0}};
    jump_addr_s = {XLEN{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (id_valid_i && id_ecall_i) begin
          pc_d    = id_pc_i;
          cause_d = ECALL_CAUSE;
          hold_s  = 1'b1;
          state_d = S_TRAP_SAVE;
        end else if (id_valid_i && id_mret_i) begin
          hold_s  = 1'b1;
          state_d = S_MRET_SAVE;
        end else if (id_valid_i && timer_pend_s) begin
          // Interrupted instruction is not executed; it resumes at mepc.
          pc_d    = id_pc_i;
          cause_d = TIMER_CAUSE;
          hold_s  = 1'b1;
          state_d = S_TRAP_SAVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRAP_SAVE: begin
        wen_s         = 1'b1;
        hold_s        = 1'b1;
        mepc_s        = pc_q;
        mcause_s      = cause_q;
        mstatus_s     = csr_mstatus_i;
        mstatus_s[7]  = csr_mstatus_i[3];
        mstatus_s[3]  = 1'b0;
        mstatus_s[12:11] = 2'b11;
        // Direct mode only: the low mode bits of mtvec are dropped.
        target_d      = csr_mtvec_i & {{(XLEN-2){1'b1}}, 2'b00};
        state_d       = S_JUMP;
      end
      S_MRET_SAVE: begin
        wen_s         = 1'b1;
        hold_s        = 1'b1;
        mepc_s        = csr_mepc_i;
        mcause_s      = csr_mcause_i;
        mstatus_s     = csr_mstatus_i;
        mstatus_s[3]  = csr_mstatus_i[7];
        mstatus_s[7]  = 1'b1;
        mstatus_s[12:11] = 2'b11;
        target_d      = csr_mepc_i;
        state_d       = S_JUMP;
      end
      S_JUMP: begin
        jump_s      = 1'b1;
        hold_s      = 1'b1;
        jump_addr_s = target_q;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched trap context and timer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      pc_q       <= {XLEN{1'b0}};
      cause_q    <= {XLEN{1'b0}};
      target_q   <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      mtime_q  <= mtime_q + 64'd1;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
      if (mtimecmp_wen_i) begin
        mtimecmp_q <= mtimecmp_wdata_i;
      end
    end
  end

  // Outputs are forced quiet while reset is asserted so an aborted
  // sequence cannot leak a CSR write or a jump in the reset cycle.
  assign clint_csr_wen_o = rst & wen_s;
  assign hold_o          = rst & hold_s;
  assign jump_o          = rst & jump_s;
  assign busy_o          = rst & (state_q != S_IDLE);
  assign mepc_o          = rst ? mepc_s      : {XLEN{1'b0}};
  assign mcause_o        = rst ? mcause_s    : {XLEN{1'b0}};
  assign mstatus_o       = rst ? mstatus_s   : {XLEN{1'b0}};
  assign jump_addr_o     = rst ? jump_addr_s : {XLEN{1'b0}};
  assign mtime_o         = mtime_q;

endmodule

// File: tb/tb_clint_ctrl.sv
// Self-checking bench for clint_ctrl: directed vector table, hand-written
// timer/reset/wrap sequences, and a randomized run against a queue model.
module tb_clint_ctrl;
  localparam logic [63:0] ECALL_C = 64'd11;
  localparam logic [63:0] TIMER_C = 64'h8000_0000_0000_0007;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Z       = 64'h0;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_ecall, id_mret, cmp_wen;
  logic [63:0] id_pc, mtvec, mepc_in, mcause_in, mstatus_in, cmp_wdata;
  logic        wen_o, hold_o, jump_o, busy_o;
  logic [63:0] mepc_o, mcause_o, mstatus_o, jaddr_o, mtime_o;

  int tests = 0;
  int fails = 0;

  clint_ctrl #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_ecall_i(id_ecall), .id_mret_i(id_mret), .id_pc_i(id_pc),
    .csr_mtvec_i(mtvec), .csr_mepc_i(mepc_in), .csr_mcause_i(mcause_in), .csr_mstatus_i(mstatus_in),
    .mtimecmp_wen_i(cmp_wen), .mtimecmp_wdata_i(cmp_wdata),
    .clint_csr_wen_o(wen_o), .mepc_o(mepc_o), .mcause_o(mcause_o), .mstatus_o(mstatus_o),
    .hold_o(hold_o), .jump_o(jump_o), .jump_addr_o(jaddr_o), .mtime_o(mtime_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, v, ec, mr, cw;
    logic [63:0] pc, tv, ep, ms, cd;
    logic h, w, j, b;
    logic [63:0] em, emc, es, ej;
  } vec_t;

  typedef struct {
    int kind;            // 0 trap save, 1 mret save, 2 jump
    logic [63:0] pc, cause, target;
  } ev_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic h, input logic w, input logic j, input logic b,
                            input logic [63:0] em, input logic [63:0] emc, input logic [63:0] es, input logic [63:0] ej);
    check({nm, ".hold"}, {63'd0, hold_o}, {63'd0, h});
    check({nm, ".wen"}, {63'd0, wen_o}, {63'd0, w});
    check({nm, ".jump"}, {63'd0, jump_o}, {63'd0, j});
    check({nm, ".busy"}, {63'd0, busy_o}, {63'd0, b});
    check({nm, ".mepc"}, mepc_o, em);
    check({nm, ".mcause"}, mcause_o, emc);
    check({nm, ".mstatus"}, mstatus_o, es);
    check({nm, ".jaddr"}, jaddr_o, ej);
  endtask

  task automatic set_in(input logic r, input logic v, input logic ec, input logic mr,
                        input logic [63:0] pc, input logic [63:0] ms, input logic cw, input logic [63:0] cd);
    rst = r; id_valid = v; id_ecall = ec; id_mret = mr; id_pc = pc;
    mstatus_in = ms; cmp_wen = cw; cmp_wdata = cd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, Z, Z, 1'b0, Z);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [63:0] trap_ms(input logic [63:0] ms);
    logic [63:0] r;
    r = ms; r[7] = ms[3]; r[3] = 1'b0; r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [63:0] mret_ms(input logic [63:0] ms);
    logic [63:0] r;
    r = ms; r[3] = ms[7]; r[7] = 1'b1; r[12:11] = 2'b11;
    return r;
  endfunction

  vec_t tbl[18];

  initial begin
    logic        accepted;
    logic [63:0] acc_time;
    int          holds;
    ev_t         q[$];
    ev_t         cur, nxt;
    logic [63:0] m_time, m_cmp;
    logic        pend, eh, ew, ej, eb;
    logic [63:0] em, emc, es, ea;

    set_in(1'b0, 1'b0, 1'b0, 1'b0, Z, Z, 1'b0, Z);
    mtvec = Z; mepc_in = Z; mcause_in = 64'd42;

    //            r    v    ec   mr   cw   pc                     mtvec                  mepc                   mstatus     cdat  h    w    j    b    mepc_o                 mcause_o  mstatus_o   jump_addr
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, Z,                     Z,                     Z,                     Z,          Z,    1'b0,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, Z,                     Z,                     Z,                     Z,          Z,    1'b0,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 64'h8000_0010,         64'h8000_0103,         Z,                     64'h8,      Z,    1'b1,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 64'h8000_0010,         64'h8000_0103,         Z,                     64'h8,      Z,    1'b1,1'b1,1'b0,1'b1, 64'h8000_0010,         ECALL_C,  64'h1880,   Z};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 64'h8000_0010,         64'h8000_0103,         Z,                     64'h8,      Z,    1'b1,1'b0,1'b1,1'b1, Z,                     Z,        Z,          64'h8000_0100};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, Z,                     64'h8000_0103,         Z,                     64'h1880,   Z,    1'b0,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 64'h8000_0024,         64'h8000_0103,         64'h8000_0014,         64'h1880,   Z,    1'b1,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 64'h8000_0024,         64'h8000_0103,         64'h8000_0014,         64'h1880,   Z,    1'b1,1'b1,1'b0,1'b1, 64'h8000_0014,         64'd42,   64'h1888,   Z};
    tbl[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 64'h8000_0024,         64'h8000_0103,         64'h8000_0014,         64'h1880,   Z,    1'b1,1'b0,1'b1,1'b1, Z,                     Z,        Z,          64'h8000_0014};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, Z,                     64'h8000_0103,         Z,                     64'h8,      Z,    1'b0,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 64'h8000_0020,         64'h8000_0103,         Z,                     64'h8,      Z,    1'b1,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 64'h8000_0020,         64'h8000_0103,         Z,                     64'h8,      Z,    1'b1,1'b1,1'b0,1'b1, 64'h8000_0020,         ECALL_C,  64'h1880,   Z};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 64'h8000_0020,         64'h8000_0103,         Z,                     64'h8,      Z,    1'b1,1'b0,1'b1,1'b1, Z,                     Z,        Z,          64'h8000_0100};
    tbl[13] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 64'h8000_0030,         64'h8000_0103,         Z,                     Z,          Z,    1'b0,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 64'h8000_0030,         64'h8000_0103,         Z,                     64'h8,      Z,    1'b1,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};
    tbl[15] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 64'h8000_0034,         64'h8000_0201,         Z,                     64'h8,      Z,    1'b1,1'b1,1'b0,1'b1, 64'h8000_0030,         TIMER_C,  64'h1880,   Z};
    tbl[16] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 64'h8000_0034,         64'h8000_0201,         Z,                     64'h8,      Z,    1'b1,1'b0,1'b1,1'b1, Z,                     Z,        Z,          64'h8000_0200};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,1'b1, Z,                     64'h8000_0201,         Z,                     Z,          ONES, 1'b0,1'b0,1'b0,1'b0, Z,                     Z,        Z,          Z};

    // Directed table: ecall, mret, ecall beating a pending timer, timer trap.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      set_in(tbl[i].r, tbl[i].v, tbl[i].ec, tbl[i].mr, tbl[i].pc, tbl[i].ms, tbl[i].cw, tbl[i].cd);
      mtvec = tbl[i].tv; mepc_in = tbl[i].ep;
      #1;
      check_outs($sformatf("vec%0d", i), tbl[i].h, tbl[i].w, tbl[i].j, tbl[i].b,
                 tbl[i].em, tbl[i].emc, tbl[i].es, tbl[i].ej);
    end

    // Reset asserted while in TRAP_SAVE aborts the sequence.
    @(negedge clk); set_in(1'b1, 1'b0, 1'b0, 1'b0, Z, 64'h8, 1'b1, Z);
    @(negedge clk); set_in(1'b1, 1'b1, 1'b1, 1'b0, 64'h8000_0050, 64'h8, 1'b0, Z);
    #1 check("rst_mid.accept", {63'd0, hold_o}, 64'd1);
    @(negedge clk); rst = 1'b0;
    #1 check_outs("rst_mid.rcycle", 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, Z, Z);
    @(negedge clk); set_in(1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0054, 64'h8, 1'b0, Z);
    #1 check_outs("rst_mid.after", 1'b0, 1'b0, 1'b0, 1'b0, Z, Z, Z, Z);
    check("rst_mid.mtime", mtime_o, Z);
    @(negedge clk);
    #1 check("rst_mid.nojump", {63'd0, jump_o}, Z);
    check("rst_mid.cmp_ones", {63'd0, hold_o}, Z);
    check("rst_mid.mtime1", mtime_o, 64'd1);

    // Timer interrupt: mtimecmp=20 written when mtime=5.
    do_reset();
    accepted = 1'b0; acc_time = Z;
    for (int c = 0; c < 60 && !accepted; c++) begin
      if (c != 0) @(negedge clk);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0040, 64'h8, (mtime_o == 64'd5), 64'd20);
      #1;
      if (hold_o) begin accepted = 1'b1; acc_time = mtime_o; end
    end
    check("timer.accepted", {63'd0, accepted}, 64'd1);
    check("timer.accept_time", acc_time, 64'd20);
    @(negedge clk); set_in(1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0044, 64'h8, 1'b0, Z);
    #1 check_outs("timer.save", 1'b1, 1'b1, 1'b0, 1'b1, 64'h8000_0040, TIMER_C, 64'h1880, Z);

    // Same timer with MIE clear: never taken.
    do_reset();
    holds = 0;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0040, Z, (mtime_o == 64'd5), 64'd20);
      #1;
      if (hold_o) holds++;
    end
    check("timer_mie0.holds", holds, Z);

    // mtime wraparound with mtimecmp at its reset value.
    do_reset();
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, Z, 64'h8, 1'b0, Z);
    force dut.mtime_q = ONES;
    #1 release dut.mtime_q;
    id_valid = 1'b1;
    #1 check("wrap.mtime_ones", mtime_o, ONES);
    check("wrap.pend_ones", {63'd0, hold_o}, 64'd1);
    id_valid = 1'b0;
    @(negedge clk); id_valid = 1'b1;
    #1 check("wrap.mtime_zero", mtime_o, Z);
    check("wrap.pend_zero", {63'd0, hold_o}, Z);
    id_valid = 1'b0;

    // Randomized run against the transaction-queue model.
    do_reset();
    m_time = Z; m_cmp = ONES;
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      rst        = ($urandom_range(0, 39) != 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_ecall   = ($urandom_range(0, 5) == 0);
      id_mret    = ($urandom_range(0, 5) == 0);
      id_pc      = {$urandom, $urandom};
      mtvec      = {$urandom, $urandom};
      mepc_in    = {$urandom, $urandom};
      mcause_in  = {$urandom, $urandom};
      mstatus_in = {$urandom, $urandom};
      cmp_wen    = ($urandom_range(0, 7) == 0);
      cmp_wdata  = m_time + 64'($urandom_range(0, 12)) - 64'd4;
      #1;
      pend = (m_time >= m_cmp) && mstatus_in[3];
      eh = 1'b0; ew = 1'b0; ej = 1'b0; eb = 1'b0;
      em = Z; emc = Z; es = Z; ea = Z;
      if (rst) begin
        if (q.size() != 0) begin
          eb = 1'b1; eh = 1'b1;
          if (q[0].kind == 0) begin
            ew = 1'b1; em = q[0].pc; emc = q[0].cause; es = trap_ms(mstatus_in);
          end else if (q[0].kind == 1) begin
            ew = 1'b1; em = mepc_in; emc = mcause_in; es = mret_ms(mstatus_in);
          end else begin
            ej = 1'b1; ea = q[0].target;
          end
        end else begin
          eh = id_valid && (id_ecall || id_mret || pend);
        end
      end
      check_outs($sformatf("rnd%0d", c), eh, ew, ej, eb, em, emc, es, ea);
      check($sformatf("rnd%0d.mtime", c), mtime_o, m_time);
      if (!rst) begin
        q.delete(); m_time = Z; m_cmp = ONES;
      end else begin
        if (q.size() != 0) begin
          cur = q.pop_front();
          if (cur.kind != 2) begin
            nxt.kind = 2; nxt.pc = Z; nxt.cause = Z;
            nxt.target = (cur.kind == 0) ? (mtvec & ~64'h3) : mepc_in;
            q.push_back(nxt);
          end
        end else if (id_valid && (id_ecall || id_mret || pend)) begin
          nxt.target = Z;
          nxt.pc     = id_pc;
          nxt.kind   = id_ecall ? 0 : (id_mret ? 1 : 0);
          nxt.cause  = id_ecall ? ECALL_C : TIMER_C;
          q.push_back(nxt);
        end
        m_time = m_time + 64'd1;
        if (cmp_wen) m_cmp = cmp_wdata;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
